// File: rtl/acq_pkg.sv
// Shared types and constants for the acquisition sequencer.
// Frame layout is {ch7..ch0}, each channel SAMPLE_W bits wide.
package acq_pkg;

  localparam int NUM_CH   = 8;
  localparam int SAMPLE_W = 14;
  localparam int FRAME_W  = NUM_CH * SAMPLE_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_INIT_WT = 3'd2,
    S_CFG     = 3'd3,
    S_CFG_WT  = 3'd4,
    S_RUN     = 3'd5,
    S_CONV    = 3'd6,
    S_ERR     = 3'd7
  } state_t;

endpackage

// File: rtl/acq_sequencer_if.sv
// ADC-side control/data and the downstream frame port of the sequencer.
// Frame handshake: a frame moves when frame_vld && frame_rdy are both high at a clk edge;
// frame_vld stays high and frame_dat stays stable until that edge.
interface acq_sequencer_if;
  import acq_pkg::*;

  logic               ad_ena;
  logic               init_adc;
  logic               cfg_adc;
  logic               st_adc;
  logic               val_dat;
  logic [FRAME_W-1:0] ad_dat;
  logic [FRAME_W-1:0] frame_dat;
  logic               frame_vld;
  logic               frame_rdy;

  modport master (
    output ad_ena, init_adc, cfg_adc, st_adc, frame_dat, frame_vld,
    input  val_dat, ad_dat, frame_rdy
  );

  modport slave (
    input  ad_ena, init_adc, cfg_adc, st_adc, frame_dat, frame_vld,
    output val_dat, ad_dat, frame_rdy
  );

endinterface

// File: rtl/acq_tick_gen.sv
// Sweep period counter: counts 0..eff_per-1 while enabled and ticks on the last count.
// The clamped period is latched while idle and again at every wrap, so changes never cut a count short.
module acq_tick_gen #(
  parameter int PER_W      = 24,
  parameter int MIN_PERIOD = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PER_W-1:0] period,
  output logic             tick
);

  logic [PER_W-1:0] cnt;
  logic [PER_W-1:0] last_q;
  logic [PER_W-1:0] eff_per;

  assign eff_per = (period < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : period;
  assign tick    = en && (cnt == last_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      last_q <= '0;
    end else if (!en || tick) begin
      cnt    <= '0;
      last_q <= eff_per - PER_W'(1);
    end else begin
      cnt <= cnt + PER_W'(1);
    end
  end

endmodule

// File: rtl/acq_sequencer.sv
// ADC acquisition sequencer: init/config bring-up, periodic sweeps, frame capture
// with a single-entry downstream buffer, and sticky overrun/timeout/drop reporting.
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int SETTLE_CYC  = 64,
  parameter int TIMEOUT_CYC = 4096,
  parameter int MIN_PERIOD  = 256,
  parameter int PER_W       = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PER_W-1:0]      period,
  input  logic                  clr_err,
  acq_sequencer_if.master       bus,
  output logic                  overrun,
  output logic                  timeout_err,
  output logic [7:0]            drop_cnt,
  output logic                  busy,
  output state_t                dbg_state
);

  localparam int CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             run_en;
  logic             tick;
  logic             accept;
  logic             drop;
  logic             settle_done;
  logic             to_done;

  assign run_en      = (state == S_RUN) || (state == S_CONV);
  assign accept      = bus.val_dat && (state == S_CONV);
  assign drop        = accept && bus.frame_vld && !bus.frame_rdy;
  assign settle_done = (cnt == CNT_W'(SETTLE_CYC - 1));
  assign to_done     = (cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign busy        = (state != S_IDLE) && (state != S_ERR);
  assign dbg_state   = state;

  acq_tick_gen #(
    .PER_W      (PER_W),
    .MIN_PERIOD (MIN_PERIOD)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (run_en),
    .period (period),
    .tick   (tick)
  );

  // Pulses are issued on the edge that leaves the issuing state; gating with en drops a pending pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bus.ad_ena   <= 1'b0;
      bus.init_adc <= 1'b0;
      bus.cfg_adc  <= 1'b0;
      bus.st_adc   <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      bus.ad_ena   <= en && (state != S_IDLE) && (state != S_ERR);
      bus.init_adc <= en && (state == S_INIT);
      bus.cfg_adc  <= en && (state == S_CFG);
      bus.st_adc   <= en && (state == S_RUN) && tick;

      if ((state == S_CONV) && tick)                      overrun <= 1'b1;
      else if (clr_err)                                   overrun <= 1'b0;

      if (en && (state == S_CONV) && !accept && to_done)  timeout_err <= 1'b1;
      else if (clr_err)                                   timeout_err <= 1'b0;

      cnt <= '0;
      if (!en) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE:    state <= S_INIT;
          S_INIT:    state <= S_INIT_WT;
          S_INIT_WT: if (settle_done) state <= S_CFG;
                     else             cnt   <= cnt + CNT_W'(1);
          S_CFG:     state <= S_CFG_WT;
          S_CFG_WT:  if (settle_done) state <= S_RUN;
                     else             cnt   <= cnt + CNT_W'(1);
          S_RUN:     if (tick) state <= S_CONV;
          S_CONV:    if (accept)       state <= S_RUN;
                     else if (to_done) state <= S_ERR;
                     else              cnt   <= cnt + CNT_W'(1);
          S_ERR:     if (clr_err) state <= S_IDLE;
          default:   state <= S_IDLE;
        endcase
      end
    end
  end

  // A simultaneous consume frees the buffer for the incoming sweep; otherwise a full buffer drops it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.frame_dat <= '0;
      bus.frame_vld <= 1'b0;
      drop_cnt      <= 8'd0;
    end else begin
      if (accept && (!bus.frame_vld || bus.frame_rdy)) begin
        bus.frame_dat <= bus.ad_dat;
        bus.frame_vld <= 1'b1;
      end else if (bus.frame_vld && bus.frame_rdy) begin
        bus.frame_vld <= 1'b0;
      end

      if (clr_err)                          drop_cnt <= drop ? 8'd1 : 8'd0;
      else if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer: bring-up timing, sweep period/clamp, overrun,
// frame buffering and drops, timeout, enable drop and asynchronous reset.
module tb_acq_sequencer;
  import acq_pkg::*;

  localparam int PER_W   = 24;
  localparam int TIMEOUT = 4096;
  localparam int W_INIT  = 0;
  localparam int W_CFG   = 1;
  localparam int W_ST    = 2;
  localparam int W_TO    = 3;
  localparam int W_SCFG  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             clr_err;
  logic [PER_W-1:0] period;
  logic             overrun;
  logic             timeout_err;
  logic [7:0]       drop_cnt;
  logic             busy;
  state_t           dbg_state;

  acq_sequencer_if bus_if ();

  acq_sequencer #(
    .SETTLE_CYC  (64),
    .TIMEOUT_CYC (TIMEOUT),
    .MIN_PERIOD  (256),
    .PER_W       (PER_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .period      (period),
    .clr_err     (clr_err),
    .bus         (bus_if),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .drop_cnt    (drop_cnt),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / cycle bookkeeping ----------------
  always #5 clk = ~clk;

  int cyc     = 0;
  int cfg_cnt = 0;
  int checks  = 0;
  int passes  = 0;
  logic [FRAME_W-1:0] exp_q[$];

  always @(posedge clk) begin
    cyc++;
    #1;
    if (bus_if.cfg_adc) cfg_cnt++;
  end

  // ---------------- checkers ----------------
  task automatic chk_i(input string tag, input int obs, input int want);
    checks++;
    assert (obs === want) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
  endtask

  task automatic chk_w(input string tag, input logic [FRAME_W-1:0] obs, input logic [FRAME_W-1:0] want);
    checks++;
    assert (obs === want) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, want);
  endtask

  // Scoreboard: pops on every accepted frame, sampled after inputs settle and before the next edge.
  always @(negedge clk) begin
    #1;
    if (bus_if.frame_vld && bus_if.frame_rdy) begin
      if (exp_q.size() == 0) chk_i("sb_unexpected_frame", 1, 0);
      else                   chk_w("sb_frame_dat", bus_if.frame_dat, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_for(input string tag, input int which, input int budget, output int at);
    bit seen;
    seen = 1'b0;
    at   = -1;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      case (which)
        W_INIT:  seen = bus_if.init_adc;
        W_CFG:   seen = bus_if.cfg_adc;
        W_ST:    seen = bus_if.st_adc;
        W_TO:    seen = timeout_err;
        default: seen = (dbg_state == S_CFG);
      endcase
      if (seen) at = cyc;
    end
    if (!seen) chk_i({tag, "_wait_expired"}, 0, 1);
  endtask

  task automatic send_val(input int delay, input logic [FRAME_W-1:0] d);
    repeat (delay) @(negedge clk);
    bus_if.ad_dat  = d;
    bus_if.val_dat = 1'b1;
    @(negedge clk);
    bus_if.val_dat = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  function automatic logic [FRAME_W-1:0] rnd_frame();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[FRAME_W-1:0];
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int t0, t_init, t_cfg, t_st, t_prev, t_to, t_clr, t_scfg, c_cfg;
    logic [FRAME_W-1:0] f, f_held;

    rst = 1'b0; en = 1'b0; clr_err = 1'b0; period = PER_W'(1000);
    bus_if.val_dat = 1'b0; bus_if.ad_dat = '0; bus_if.frame_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk_i("rst_state", int'(dbg_state), int'(S_IDLE));
    chk_i("rst_outs", int'({bus_if.ad_ena, bus_if.init_adc, bus_if.cfg_adc, bus_if.st_adc,
                            bus_if.frame_vld, overrun, timeout_err, busy}), 0);
    chk_i("rst_drop_cnt", int'(drop_cnt), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: bring-up timing
    en = 1'b1; t0 = cyc;
    wait_for("init", W_INIT, 10, t_init);
    chk_i("init_at_cycle2", t_init - t0, 2);
    chk_i("ad_ena_with_init", int'(bus_if.ad_ena), 1);
    @(negedge clk);
    chk_i("init_one_cycle", int'(bus_if.init_adc), 0);
    wait_for("cfg", W_CFG, 100, t_cfg);
    chk_i("cfg_after_init", t_cfg - t_init, 65);
    chk_i("ad_ena_at_cfg", int'(bus_if.ad_ena), 1);
    wait_for("st0", W_ST, 1200, t_st);
    chk_i("st0_after_cfg", t_st - t_cfg, 64 + 1000);
    chk_i("st0_state_conv", int'(dbg_state), int'(S_CONV));

    // 2: steady sweeps, period 1000, val_dat 300 after st_adc
    t_prev = t_st;
    f = rnd_frame(); exp_q.push_back(f); send_val(300, f);
    for (int i = 0; i < 3; i++) begin
      wait_for("st_t2", W_ST, 1100, t_st);
      chk_i("t2_st_spacing", t_st - t_prev, 1000);
      t_prev = t_st;
      f = rnd_frame(); exp_q.push_back(f); send_val(300, f);
    end
    chk_i("t2_no_flags", int'({overrun, timeout_err}), 0);
    chk_i("t2_no_drops", int'(drop_cnt), 0);

    // 3: period 100 clamps to 256; slow conversion overruns
    period = PER_W'(100);
    wait_for("st_t3a", W_ST, 1100, t_st);
    chk_i("t3_no_truncate", t_st - t_prev, 1000);
    t_prev = t_st;
    chk_i("t3_overrun_before", int'(overrun), 0);
    f = rnd_frame(); exp_q.push_back(f); send_val(400, f);
    chk_i("t3_overrun_set", int'(overrun), 1);
    wait_for("st_t3b", W_ST, 600, t_st);
    chk_i("t3_skip_spacing", t_st - t_prev, 512);
    chk_i("t3_no_timeout", int'(timeout_err), 0);
    t_prev = t_st;
    period = PER_W'(1000);
    f = rnd_frame(); exp_q.push_back(f); send_val(100, f);
    wait_for("st_t3c", W_ST, 300, t_st);
    chk_i("t3_clamped_spacing", t_st - t_prev, 256);
    t_prev = t_st;

    // 4: downstream stalled across three sweeps
    bus_if.frame_rdy = 1'b0;
    f_held = rnd_frame(); exp_q.push_back(f_held); send_val(300, f_held);
    for (int i = 0; i < 2; i++) begin
      wait_for("st_t4", W_ST, 1100, t_st);
      chk_i("t4_st_spacing", t_st - t_prev, 1000);
      t_prev = t_st;
      send_val(300, rnd_frame());
    end
    chk_i("t4_drop_cnt", int'(drop_cnt), 2);
    chk_i("t4_vld_held", int'(bus_if.frame_vld), 1);
    pulse_clr();
    chk_i("t4_clr_drop_cnt", int'(drop_cnt), 0);
    chk_i("t4_clr_overrun", int'(overrun), 0);
    bus_if.frame_rdy = 1'b1;
    @(negedge clk);
    chk_i("t4_vld_cleared", int'(bus_if.frame_vld), 0);

    // 5: no val_dat -> timeout, error state, clear, restart
    wait_for("st_t5", W_ST, 1100, t_st);
    wait_for("timeout", W_TO, TIMEOUT + 100, t_to);
    chk_i("t5_timeout_time", t_to - t_st, TIMEOUT);
    chk_i("t5_state_err", int'(dbg_state), int'(S_ERR));
    chk_i("t5_not_busy", int'(busy), 0);
    @(negedge clk);
    chk_i("t5_ad_ena_low", int'(bus_if.ad_ena), 0);
    t_clr = cyc;
    pulse_clr();
    chk_i("t5_state_idle", int'(dbg_state), int'(S_IDLE));
    chk_i("t5_timeout_clr", int'(timeout_err), 0);
    wait_for("init_t5", W_INIT, 10, t_init);
    chk_i("t5_reinit", t_init - t_clr, 3);

    // 6: enable dropped in S_CFG_WT, then exactly in S_CFG
    wait_for("cfg_t6", W_CFG, 100, t_cfg);
    c_cfg = cfg_cnt;
    en = 1'b0;
    @(negedge clk);
    chk_i("t6_idle_after_drop", int'(dbg_state), int'(S_IDLE));
    chk_i("t6_ad_ena_drop", int'(bus_if.ad_ena), 0);
    repeat (5) @(negedge clk);
    en = 1'b1; t0 = cyc;
    wait_for("init_t6", W_INIT, 10, t_init);
    chk_i("t6_fresh_init", t_init - t0, 2);
    chk_i("t6_no_cfg_before_init", cfg_cnt, c_cfg);
    wait_for("scfg_t6", W_SCFG, 100, t_scfg);
    chk_i("t6_cfg_state_at", t_scfg - t_init, 64);
    c_cfg = cfg_cnt;
    en = 1'b0;
    repeat (4) @(negedge clk);
    chk_i("t6_cfg_suppressed", cfg_cnt, c_cfg);

    // reset in the middle of a conversion
    bus_if.frame_rdy = 1'b0;
    en = 1'b1;
    wait_for("st_t6a", W_ST, 1300, t_st);
    f = rnd_frame(); send_val(100, f);
    wait_for("st_t6b", W_ST, 1100, t_st);
    repeat (50) @(negedge clk);
    chk_i("t6_pre_rst_state", int'(dbg_state), int'(S_CONV));
    chk_w("t6_pre_rst_frame", bus_if.frame_dat, f);
    rst = 1'b0;
    #1;
    chk_i("t6_rst_outs", int'({bus_if.ad_ena, bus_if.init_adc, bus_if.cfg_adc, bus_if.st_adc,
                               bus_if.frame_vld, overrun, timeout_err, busy}), 0);
    chk_w("t6_rst_frame_dat", bus_if.frame_dat, '0);
    chk_i("t6_rst_state", int'(dbg_state), int'(S_IDLE));
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_i("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
